// File: rtl/encode_mod_rm.sv
// encode_mod_rm
//   Serializes an x86 ModR/M encoding (ModR/M, optional SIB, 0/1/2/4-byte
//   little-endian displacement) onto a byte stream with valid/ready handshake.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   req_valid/req_ready request handshake; fields latched on acceptance
//   addr_size_32        1 = 32-bit addressing rules, 0 = 16-bit
//   mod, reg_fld, rm    ModR/M fields (reg_fld carries the "reg" field;
//                       "reg" itself is a reserved word)
//   scale, index, base  SIB fields
//   disp                displacement, low 1/2/4 bytes used
//   out_valid/out_ready output handshake, one byte per transfer
//   out_byte, out_last  current byte, final-byte flag
//   out_length          total bytes of the encoding in flight (1..6)
module encode_mod_rm (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        addr_size_32,
    input  logic [1:0]  mod,
    input  logic [2:0]  reg_fld,
    input  logic [2:0]  rm,
    input  logic [1:0]  scale,
    input  logic [2:0]  index,
    input  logic [2:0]  base,
    input  logic [31:0] disp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [2:0]  out_length
);

    typedef enum logic [1:0] {IDLE, MODRM, SIB, DISP} state_t;

    typedef struct packed {
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic [31:0] disp;
        logic        sib_en;
        logic [2:0]  dlen;
    } enc_t;

    state_t     state, state_nxt;
    enc_t       enc;
    logic [1:0] idx;
    logic       init_done;
    logic       need_sib;
    logic [2:0] dlen_in;
    logic       accept, fire, disp_last;

    // Decode of the incoming request, used only at acceptance.
    assign need_sib = addr_size_32 && (mod != 2'b11) && (rm == 3'b100);

    always_comb begin
        dlen_in = 3'd0;
        if (addr_size_32) begin
            case (mod)
                2'b00: if (rm == 3'b101 || (need_sib && base == 3'b101)) dlen_in = 3'd4;
                2'b01: dlen_in = 3'd1;
                2'b10: dlen_in = 3'd4;
                default: dlen_in = 3'd0;
            endcase
        end else begin
            case (mod)
                2'b00: if (rm == 3'b110) dlen_in = 3'd2;
                2'b01: dlen_in = 3'd1;
                2'b10: dlen_in = 3'd2;
                default: dlen_in = 3'd0;
            endcase
        end
    end

    // init_done keeps req_ready low while reset is held and lets it rise on
    // the first edge after release, even though the state is already IDLE.
    assign req_ready = (state == IDLE) && init_done;
    assign accept    = req_valid && req_ready;
    assign out_valid = (state != IDLE);
    assign fire      = out_valid && out_ready;
    assign disp_last = ({1'b0, idx} == (enc.dlen - 3'd1));

    always_comb begin
        state_nxt = state;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = MODRM;
            end
            MODRM: begin
                out_byte = enc.modrm;
                out_last = !enc.sib_en && (enc.dlen == 3'd0);
                if (fire) begin
                    if (enc.sib_en)            state_nxt = SIB;
                    else if (enc.dlen != 3'd0) state_nxt = DISP;
                    else                       state_nxt = IDLE;
                end
            end
            SIB: begin
                out_byte = enc.sib;
                out_last = (enc.dlen == 3'd0);
                if (fire) state_nxt = (enc.dlen != 3'd0) ? DISP : IDLE;
            end
            DISP: begin
                out_byte = enc.disp[{idx, 3'b000} +: 8];
                out_last = disp_last;
                if (fire && disp_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            init_done  <= 1'b0;
            enc        <= '0;
            idx        <= 2'd0;
            out_length <= 3'd0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
            if (accept) begin
                enc.modrm  <= {mod, reg_fld, rm};
                enc.sib    <= {scale, index, base};
                enc.disp   <= disp;
                enc.sib_en <= need_sib;
                enc.dlen   <= dlen_in;
                out_length <= 3'd1 + {2'b00, need_sib} + dlen_in;
            end
            // Byte index walks the displacement; cleared outside DISP.
            if (state != DISP)  idx <= 2'd0;
            else if (fire)      idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_encode_mod_rm.sv
module tb_encode_mod_rm;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, addr_size_32;
    logic [1:0]  mod, scale;
    logic [2:0]  reg_fld, rm, index, base;
    logic [31:0] disp;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  out_byte;
    logic [2:0]  out_length;

    int errs   = 0;
    int checks = 0;

    always #5 clock = ~clock;

    encode_mod_rm dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .addr_size_32(addr_size_32), .mod(mod), .reg_fld(reg_fld), .rm(rm),
        .scale(scale), .index(index), .base(base), .disp(disp),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .out_length(out_length)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request (waiting for req_ready), then scramble the fields so
    // any late sampling by the DUT shows up as corrupted bytes.
    task automatic send(input string tag, input logic a32, input logic [1:0] m,
                        input logic [2:0] r, input logic [2:0] mrm, input logic [1:0] sc,
                        input logic [2:0] ix, input logic [2:0] bs, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
        chk({tag, ":req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; addr_size_32 = a32; mod = m; reg_fld = r; rm = mrm;
        scale = sc; index = ix; base = bs; disp = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
        {addr_size_32, mod, reg_fld, rm, scale, index, base} = 17'($urandom);
        disp = $urandom;
    endtask

    // Collect n bytes; exp holds byte i at [8*i +: 8]. With stall set, ready
    // follows 1,0,0,1,0,0... and the held byte is checked on stalled cycles.
    task automatic recv(input string tag, input int n, input logic [47:0] exp,
                        input logic [2:0] len, input bit stall);
        int i = 0, cyc = 0;
        chk({tag, ":valid_lat"}, out_valid, 1'b1);
        chk({tag, ":length"}, out_length, len);
        while (i < n && cyc < 60) begin
            out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
            #1;
            if (!out_valid) begin
                chk({tag, ":valid"}, out_valid, 1'b1);
                i = n;
            end else begin
                chk({tag, ":byte"}, out_byte, exp[8*i +: 8]);
                if (out_ready) begin
                    chk({tag, ":last"}, out_last, (i == n - 1));
                    chk({tag, ":length_hold"}, out_length, len);
                    i++;
                end
                @(posedge clock); #1;
            end
            cyc++;
        end
        chk({tag, ":done_in_budget"}, (i == n), 1'b1);
        out_ready = 1'b1;
        chk({tag, ":idle_valid"}, out_valid, 1'b0);
        chk({tag, ":idle_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        addr_size_32 = 1'b0; mod = '0; reg_fld = '0; rm = '0;
        scale = '0; index = '0; base = '0; disp = '0;
        #12;
        chk("rst:out_valid", out_valid, 1'b0);
        chk("rst:out_last", out_last, 1'b0);
        chk("rst:out_byte", out_byte, 8'h00);
        chk("rst:out_length", out_length, 3'd0);
        chk("rst:req_ready", req_ready, 1'b0);
        @(negedge clock); reset = 1'b0;
        chk("rst:ready_before_edge", req_ready, 1'b0);
        @(posedge clock); #1;
        chk("rst:ready_after_edge", req_ready, 1'b1);

        send("t29", 1, 2'b01, 3'b000, 3'b100, 2'b11, 3'b110, 3'b011, 32'h20);
        recv("t29", 3, 48'h20F344, 3'd3, 0);

        send("t30a", 0, 2'b01, 3'b000, 3'b000, 2'b00, 3'b000, 3'b000, 32'h06);
        recv("t30a", 2, 48'h0640, 3'd2, 0);
        send("t30b", 0, 2'b00, 3'b000, 3'b110, 2'b00, 3'b000, 3'b000, 32'h1234);
        recv("t30b", 3, 48'h123406, 3'd3, 0);

        send("t31", 1, 2'b00, 3'b000, 3'b100, 2'b00, 3'b100, 3'b101, 32'h12345678);
        recv("t31", 6, 48'h123456782504, 3'd6, 0);

        send("t32a", 1, 2'b11, 3'b001, 3'b010, 2'b00, 3'b000, 3'b000, 32'h0);
        recv("t32a", 1, 48'hCA, 3'd1, 0);
        send("t32b", 0, 2'b11, 3'b010, 3'b100, 2'b11, 3'b111, 3'b111, 32'hFFFF);
        recv("t32b", 1, 48'hD4, 3'd1, 0);

        send("m10_32", 1, 2'b10, 3'b000, 3'b000, 2'b00, 3'b000, 3'b000, 32'hAABBCCDD);
        recv("m10_32", 5, 48'hAABBCCDD80, 3'd5, 0);
        send("m10_16", 0, 2'b10, 3'b000, 3'b111, 2'b00, 3'b000, 3'b000, 32'h5555BEEF);
        recv("m10_16", 3, 48'hBEEF87, 3'd3, 0);
        send("m00_r5", 1, 2'b00, 3'b000, 3'b101, 2'b00, 3'b000, 3'b000, 32'h11223344);
        recv("m00_r5", 5, 48'h1122334405, 3'd5, 0);
        send("sib_nod", 1, 2'b00, 3'b000, 3'b100, 2'b01, 3'b010, 3'b000, 32'hDEADBEEF);
        recv("sib_nod", 2, 48'h5004, 3'd2, 0);

        send("t33", 1, 2'b00, 3'b000, 3'b100, 2'b00, 3'b100, 3'b101, 32'h12345678);
        recv("t33", 6, 48'h123456782504, 3'd6, 1);

        // Abort mid-displacement with an asynchronous reset.
        send("t34", 1, 2'b00, 3'b000, 3'b100, 2'b00, 3'b100, 3'b101, 32'h12345678);
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        chk("t34:in_disp", out_byte, 8'h56);
        reset = 1'b1; #1;
        chk("t34:rst_valid", out_valid, 1'b0);
        chk("t34:rst_byte", out_byte, 8'h00);
        chk("t34:rst_length", out_length, 3'd0);
        chk("t34:rst_ready", req_ready, 1'b0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("t34:ready_after", req_ready, 1'b1);
        send("t34b", 1, 2'b01, 3'b000, 3'b100, 2'b11, 3'b110, 3'b011, 32'h20);
        recv("t34b", 3, 48'h20F344, 3'd3, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
